// File: rtl/rcosc_freq_monitor_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | rcosc_freq_monitor_if                                                |
// | Control and status bundle between the bootloader and the RCOSC       |
// | frequency monitor.                                                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface rcosc_freq_monitor_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             clear;
  logic             osc_toggle;
  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             freq_ok;
  logic             fault;

  modport master (
    output enable, clear, osc_toggle,
    input  count, count_valid, freq_ok, fault
  );

  modport slave (
    input  enable, clear, osc_toggle,
    output count, count_valid, freq_ok, fault
  );
endinterface
`default_nettype wire

// File: rtl/rcosc_freq_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | rcosc_freq_monitor                                                   |
// | Counts rising edges of the divided RC oscillator over a fixed gate   |
// | window and flags out-of-range windows, with a sticky fault.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rcosc_freq_monitor #(
  parameter int GATE_CYCLES = 4096,
  parameter int CNT_W       = 16,
  parameter int MIN_EDGES   = 184,
  parameter int MAX_EDGES   = 225,
  parameter int FAULT_LIMIT = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  rcosc_freq_monitor_if.slave bus
);

  localparam int c_gate_w = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int c_bad_w  = (FAULT_LIMIT > 0) ? $clog2(FAULT_LIMIT + 1) : 1;

  localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    c_min_edges = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0]    c_max_edges = CNT_W'(MAX_EDGES);
  localparam logic [c_bad_w-1:0]  c_bad_limit = c_bad_w'(FAULT_LIMIT);

  localparam logic [1:0] c_st_idle    = 2'd0;
  localparam logic [1:0] c_st_measure = 2'd1;
  localparam logic [1:0] c_st_report  = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  logic                w_edge;
  logic [c_gate_w-1:0] r_gate;
  logic [CNT_W-1:0]    r_edge_cnt;
  logic [c_bad_w-1:0]  r_bad;
  logic [CNT_W-1:0]    r_count;
  logic                r_count_valid;
  logic                r_freq_ok;
  logic                r_fault;

  logic                w_measuring;
  logic                w_report;
  logic                w_idle;
  logic                w_gate_done;
  logic                w_in_range;
  logic [c_bad_w-1:0]  w_bad_inc;
  logic [c_bad_w-1:0]  w_bad_rpt;
  logic                w_fault_set;

  // OSC_TOGGLE is asynchronous: two flops for metastability, a third as edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.osc_toggle;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_edge      = r_s2 & ~r_s3;
  assign w_gate_done = (r_gate == c_gate_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dropping ENABLE mid-window abandons it, even on the last gate cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (bus.enable) w_state_nxt = c_st_measure;
      end
      c_st_measure: begin
        if (!bus.enable)      w_state_nxt = c_st_idle;
        else if (w_gate_done) w_state_nxt = c_st_report;
      end
      c_st_report: begin
        w_state_nxt = bus.enable ? c_st_measure : c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_measuring = 1'b0;
    w_report    = 1'b0;
    case (r_state)
      c_st_measure: w_measuring = 1'b1;
      c_st_report:  w_report    = 1'b1;
      default: begin
        w_measuring = 1'b0;
        w_report    = 1'b0;
      end
    endcase
    w_idle = ~(w_measuring | w_report);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate <= '0;
    end else if (w_measuring && !w_gate_done) begin
      r_gate <= r_gate + c_gate_w'(1);
    end else begin
      r_gate <= '0;
    end
  end

  // An edge seen during REPORT opens the next window so no edge is lost between windows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_edge_cnt <= '0;
    end else if (w_measuring) begin
      if (w_edge && (r_edge_cnt != c_cnt_max)) begin
        r_edge_cnt <= r_edge_cnt + CNT_W'(1);
      end
    end else if (w_report) begin
      r_edge_cnt <= CNT_W'(w_edge & bus.enable);
    end else begin
      r_edge_cnt <= '0;
    end
  end

  assign w_in_range  = (r_edge_cnt >= c_min_edges) && (r_edge_cnt <= c_max_edges);
  assign w_bad_inc   = (r_bad == c_bad_limit) ? r_bad : (r_bad + c_bad_w'(1));
  assign w_bad_rpt   = w_in_range ? '0 : w_bad_inc;
  assign w_fault_set = w_report && !w_in_range && (w_bad_inc == c_bad_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count       <= '0;
      r_count_valid <= 1'b0;
      r_freq_ok     <= 1'b0;
    end else begin
      r_count_valid <= w_report;
      if (w_report) begin
        r_count   <= r_edge_cnt;
        r_freq_ok <= w_in_range;
      end else if (w_idle) begin
        r_freq_ok <= 1'b0;
      end
    end
  end

  // A report landing together with CLEAR still updates the streak and may set FAULT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bad   <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_report) begin
        r_bad <= w_bad_rpt;
      end else if (bus.clear) begin
        r_bad <= '0;
      end

      if (w_fault_set) begin
        r_fault <= 1'b1;
      end else if (bus.clear) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign bus.count       = r_count;
  assign bus.count_valid = r_count_valid;
  assign bus.freq_ok     = r_freq_ok;
  assign bus.fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_rcosc_freq_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_rcosc_freq_monitor                                                |
// | Randomized bench with a timeline-based reference model.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rcosc_freq_monitor;
  localparam int GATE    = 4096;
  localparam int CW      = 16;
  localparam int MIN_E   = 184;
  localparam int MAX_E   = 225;
  localparam int LIM     = 3;
  localparam int WIN     = GATE + 1;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int MAX_CYC = 100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rcosc_freq_monitor_if #(.CNT_W(CW)) bus ();
  rcosc_freq_monitor_if #(.CNT_W(8))  bus8 ();

  rcosc_freq_monitor #(
    .GATE_CYCLES(GATE), .CNT_W(CW), .MIN_EDGES(MIN_E), .MAX_EDGES(MAX_E), .FAULT_LIMIT(LIM)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  rcosc_freq_monitor #(
    .GATE_CYCLES(GATE), .CNT_W(8), .MIN_EDGES(MIN_E), .MAX_EDGES(MAX_E), .FAULT_LIMIT(LIM)
  ) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int n_pass   = 0;
  int n_checks = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Stimulus: mode 0 = held low, 1 = square wave (per, base), 2 = random bits
  int  cyc  = 0;
  int  mode = 0;
  int  per  = 20;
  int  base = 0;
  bit  tog_prev = 1'b0;
  bit  drv_nt;
  bit  det [MAX_CYC + 8];
  int  cum [MAX_CYC + 8];

  always @(posedge clk) begin
    #1;
    case (mode)
      1:       drv_nt = ((((cyc - base) % per) + per) % per) < (per / 2);
      2:       drv_nt = 1'($urandom_range(0, 1));
      default: drv_nt = 1'b0;
    endcase
    // A rise driven now is seen by the edge counter at the third following clock
    if (drv_nt && !tog_prev) det[cyc + 3] = 1'b1;
    tog_prev       = drv_nt;
    bus.osc_toggle = drv_nt;
  end

  // Reference model: windows as absolute clock intervals, counts from a running edge tally
  bit run_active = 1'b0;
  int win_lo = 0;
  int next_report = 0;
  int n_reports = 0;
  int exp_count = 0;
  bit exp_ok = 1'b0;
  bit exp_fault = 1'b0;
  int streak = 0;
  bit exp_valid = 1'b0;
  bit chk_fault = 1'b0;
  bit m_rpt, m_sets, m_inr;
  int m_c;

  always @(posedge clk) begin
    cyc      = cyc + 1;
    cum[cyc] = cum[cyc - 1] + int'(det[cyc]);
    exp_valid = 1'b0;
    chk_fault = 1'b0;
    if (rst) begin
      run_active = 1'b0;
      streak     = 0;
      exp_fault  = 1'b0;
      exp_ok     = 1'b0;
      exp_count  = 0;
    end else begin
      m_rpt  = run_active && (cyc == next_report);
      m_sets = 1'b0;
      if (!run_active) exp_ok = 1'b0;
      if (m_rpt) begin
        m_c = cum[cyc - 1] - cum[win_lo - 1];
        if (m_c > CNT_MAX) m_c = CNT_MAX;
        m_inr     = (m_c >= MIN_E) && (m_c <= MAX_E);
        exp_count = m_c;
        exp_ok    = m_inr;
        streak    = m_inr ? 0 : ((streak < LIM) ? streak + 1 : LIM);
        m_sets    = !m_inr && (streak == LIM);
        exp_valid = 1'b1;
        n_reports++;
      end
      if (m_sets) begin
        exp_fault = 1'b1;
      end else if (bus.clear) begin
        exp_fault = 1'b0;
        if (!m_rpt) streak = 0;
        chk_fault = 1'b1;
      end
      if (!run_active) begin
        if (bus.enable) begin
          run_active  = 1'b1;
          win_lo      = cyc + 1;
          next_report = cyc + WIN;
        end
      end else if (m_rpt) begin
        if (bus.enable) begin
          win_lo      = cyc;
          next_report = cyc + WIN;
        end else begin
          run_active = 1'b0;
        end
      end else if (!bus.enable) begin
        run_active = 1'b0;
      end
    end
  end

  int obs_counts[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_valid || bus.count_valid) begin
        check_val("count_valid", longint'(bus.count_valid), longint'(exp_valid));
        if (exp_valid) begin
          check_val("count", longint'(bus.count), longint'(exp_count));
          check_val("freq_ok", longint'(bus.freq_ok), longint'(exp_ok));
          check_val("fault", longint'(bus.fault), longint'(exp_fault));
          obs_counts.push_back(int'(bus.count));
        end
      end
      if (chk_fault) check_val("fault_after_clear", longint'(bus.fault), longint'(exp_fault));
    end
  end

  task automatic wait_reports(input int k);
    int target = n_reports + k;
    int budget = k * WIN + 50;
    while ((n_reports < target) && (budget > 0)) begin
      @(posedge clk); #1;
      budget--;
    end
    if (n_reports < target) check_val("report_timeout", longint'(n_reports), longint'(target));
  endtask

  task automatic step_to(input int target_cyc);
    while (cyc < target_cyc) begin
      @(posedge clk); #1;
    end
  endtask

  // Narrow counter saturates instead of wrapping
  initial begin
    int b;
    bus8.enable = 1'b0;
    bus8.clear  = 1'b0;
    wait (!rst);
    @(posedge clk); #1;
    bus8.enable = 1'b1;
    b = 0;
    while (!bus8.count_valid && (b < WIN + 100)) begin
      @(negedge clk);
      b++;
    end
    check_val("sat8_valid", longint'(bus8.count_valid), 1);
    check_val("sat8_count", longint'(bus8.count), 255);
    @(posedge clk); #1;
    bus8.enable = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    bus8.osc_toggle = bus8.enable ? ~bus8.osc_toggle : 1'b0;
  end

  initial begin
    #(MAX_CYC * 10);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  int pseq [6] = '{16, 16, 20, 16, 16, 16};
  int p_en;
  int sum_obs;

  initial begin
    bus.enable = 1'b0;
    bus.clear  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_count", longint'(bus.count), 0);
    check_val("rst_count_valid", longint'(bus.count_valid), 0);
    check_val("rst_freq_ok", longint'(bus.freq_ok), 0);
    check_val("rst_fault", longint'(bus.fault), 0);

    // Nominal rate, two back-to-back windows
    @(posedge clk); #1;
    mode = 1; per = 20; base = cyc;
    bus.enable = 1'b1;
    wait_reports(2);

    // Fast oscillator streak, broken once by an in-range window
    for (int i = 0; i < 6; i++) begin
      per  = pseq[i];
      base = cyc;
      wait_reports(1);
    end

    // Dead oscillator: clear, then clear coinciding with the streak completing
    mode = 0;
    repeat (100) @(posedge clk);
    #1 bus.clear = 1'b1;
    @(posedge clk); #1 bus.clear = 1'b0;
    wait_reports(2);
    step_to(next_report - 1);
    bus.clear = 1'b1;
    @(posedge clk); #1 bus.clear = 1'b0;

    // Abort mid-window
    mode = 1; per = 20; base = cyc;
    step_to(win_lo + 2000);
    bus.enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("abort_freq_ok", longint'(bus.freq_ok), longint'(exp_ok));
    check_val("abort_count", longint'(bus.count), longint'(exp_count));
    check_val("abort_valid", longint'(bus.count_valid), 0);

    // Re-enable with a rise aimed at the first REPORT cycle
    p_en = cyc;
    base = cyc + WIN - 2;
    bus.enable = 1'b1;
    wait_reports(2);
    @(negedge clk); #1;
    sum_obs = 0;
    if (obs_counts.size() >= 2)
      sum_obs = obs_counts[obs_counts.size() - 1] + obs_counts[obs_counts.size() - 2];
    check_val("aligned_total", longint'(sum_obs),
              longint'(cum[p_en + 2 * WIN] - cum[p_en + 1]));

    // Randomized windows
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      per  = int'($urandom_range(17, 26));
      base = cyc - int'($urandom_range(0, 25));
      wait_reports(1);
    end
    mode = 2;
    wait_reports(1);

    // Asynchronous reset mid-window
    mode = 1; per = 19;
    repeat (1500) @(posedge clk);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("arst_count", longint'(bus.count), 0);
    check_val("arst_count_valid", longint'(bus.count_valid), 0);
    check_val("arst_freq_ok", longint'(bus.freq_ok), 0);
    check_val("arst_fault", longint'(bus.fault), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
